// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, keeps one word fetch in flight and hands the word to decode.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned PC yields a faulting nop (fetch_fault) instead of a fetch.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    output logic [XLEN-1:0] req_addr,
    input  logic            req_ready,
    input  logic            resp_valid,
    input  logic [31:0]     resp_data,
    output logic            inst_valid,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
`ifdef IFU_MISALIGN_CHECK_EN
    output logic            fetch_fault,
`endif
    input  logic            inst_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] PC_INIT = RESET_PC;
`else
    localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~(XLEN'(3));
`endif

    // Without the misalignment check every PC load is forced onto a word boundary.
    function automatic logic [XLEN-1:0] load_pc(input logic [XLEN-1:0] a);
`ifdef IFU_MISALIGN_CHECK_EN
        return a;
`else
        return a & ~(XLEN'(3));
`endif
    endfunction

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [31:0]       inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
`ifdef IFU_MISALIGN_CHECK_EN
    logic              fault_q, fault_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= PC_INIT;
            drop_q    <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= PC_INIT;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q   <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
        fault_d    = fault_q;
`endif
        req_valid  = 1'b0;
        inst_valid = 1'b0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
`ifdef IFU_MISALIGN_CHECK_EN
                if (pc_q[1:0] != 2'b00) begin
                    // A pending redirect supersedes the fault and refetches from the new PC.
                    if (!redirect_valid) begin
                        state_d   = HOLD;
                        inst_d    = NOP;
                        inst_pc_d = pc_q;
                        fault_d   = 1'b1;
                    end
                end else
`endif
                begin
                    req_valid = 1'b1;
                    if (req_ready) begin
                        state_d = WAIT;
                        drop_d  = redirect_valid;
                    end
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d    = resp_data;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (redirect_valid || inst_ready) begin
                    state_d = REQ;
`ifdef IFU_MISALIGN_CHECK_EN
                    fault_d = 1'b0;
`endif
                    if (!redirect_valid) pc_d = pc_q + XLEN'(4);
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) pc_d = load_pc(redirect_pc);
    end

    assign req_addr = pc_q;
    assign inst     = inst_q;
    assign inst_pc  = inst_pc_q;
`ifdef IFU_MISALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`endif

endmodule
